// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared burst geometry and FSM state encoding for the write DMA
package pcie_dma_pkg;
  localparam int BURST_QW    = 16;
  localparam int BURST_BYTES = 128;
  localparam int BURST_SHIFT = 7;
  typedef enum logic [1:0] {IDLE, REQ, BURST, ADV} state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int DEPTH = 64,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push  = push && count != CW'(DEPTH);
  assign do_pop   = pop && count != '0;
  assign pop_data = mem[rd_ptr];
  // storage array, written only on an accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
  // pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/pcie_write_dma.sv
// pcie_write_dma: cuts a 64-bit stream into 128-byte host ring writes for the TX formatter
module pcie_write_dma
  import pcie_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int PTR_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [63:0]      buffer_base,
  input  logic [PTR_W-1:0] buffer_blocks,
  input  logic [PTR_W-1:0] stop_ptr,
  output logic [PTR_W-1:0] write_ptr,
  output logic             ptr_update,
  input  logic [63:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             write_request_valid,
  output logic [63:0]      write_request_address,
  output logic [63:0]      write_request_data,
  input  logic             write_request_accepted
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] fifo_count, count_next;
  logic push, pop, room, sticky_err, err_n, upd_n, valid_n;
  logic [PTR_W-1:0] wp_inc, wp_n;
  logic [63:0] burst_addr, addr_n;
  logic [3:0] beat_cnt, beat_n;
  state_t state, state_n;
  assign push       = s_valid && s_ready;
  assign pop        = write_request_accepted && fifo_count != '0;
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign wp_inc     = (write_ptr + PTR_W'(1) == buffer_blocks) ? '0 : write_ptr + PTR_W'(1);
  assign room       = wp_inc != stop_ptr;
  assign burst_addr = (buffer_base & ~64'h7F) + (64'(write_ptr) << BURST_SHIFT);
  sync_fifo_fwft #(.DEPTH(FIFO_DEPTH), .W(64), .CW(CW)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (write_request_data),
    .count     (fifo_count)
  );
  // ready is registered from the next occupancy so it drops as the FIFO reaches DEPTH-1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) s_ready <= 1'b0;
    else s_ready <= count_next <= CW'(FIFO_DEPTH - 2);
  end
  // FSM state and registered request/pointer outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      beat_cnt              <= '0;
      write_ptr             <= '0;
      ptr_update            <= 1'b0;
      write_request_valid   <= 1'b0;
      write_request_address <= '0;
      sticky_err            <= 1'b0;
    end else begin
      state                 <= state_n;
      beat_cnt              <= beat_n;
      write_ptr             <= wp_n;
      ptr_update            <= upd_n;
      write_request_valid   <= valid_n;
      write_request_address <= addr_n;
      sticky_err            <= err_n;
    end
  end
  // next state: reserve a full burst before requesting, drop valid on the first beat
  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    wp_n    = write_ptr;
    upd_n   = 1'b0;
    valid_n = write_request_valid;
    addr_n  = write_request_address;
    err_n   = sticky_err;
    case (state)
      IDLE: begin
        err_n = sticky_err | write_request_accepted;
        if (enable && fifo_count >= CW'(BURST_QW) && room) begin
          state_n = REQ;
          valid_n = 1'b1;
          addr_n  = burst_addr;
          beat_n  = '0;
        end
      end
      REQ: if (write_request_accepted) begin
        valid_n = 1'b0;
        beat_n  = 4'd1;
        state_n = BURST;
      end
      BURST: if (write_request_accepted) begin
        beat_n  = beat_cnt + 4'd1;
        state_n = (beat_cnt == 4'(BURST_QW - 1)) ? ADV : BURST;
      end
      ADV: begin
        wp_n    = wp_inc;
        upd_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assert property (@(posedge clock) disable iff (!reset_n) !sticky_err);
endmodule
